clk_tick_scheduler: RTL and testbench

CLK_TICK_SCHEDULER -- requirements
Module: clk_tick_scheduler

---
 rtl/clk_tick_scheduler_if.sv | 33 +++
 rtl/clk_tick_scheduler.sv | 112 +++++++++++
 tb/tb_clk_tick_scheduler.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/clk_tick_scheduler_if.sv
// Control/status bundle for clk_tick_scheduler.
// master drives the run request and divide select; slave returns status and ticks.
interface clk_tick_scheduler_if #(
    parameter int unsigned CNT_W = 8
);
    logic             run_req;
    logic [1:0]       div_sel;
    logic             run_ack;
    logic             busy;
    logic             tick_out;
    logic [CNT_W-1:0] tick_count;
    logic [1:0]       state_o;

    modport master (
        output run_req,
        output div_sel,
        input  run_ack,
        input  busy,
        input  tick_out,
        input  tick_count,
        input  state_o
    );

    modport slave (
        input  run_req,
        input  div_sel,
        output run_ack,
        output busy,
        output tick_out,
        output tick_count,
        output state_o
    );
endinterface

// File: rtl/clk_tick_scheduler.sv
// Tick scheduler: emits a one-cycle enable every N = 2^(div_sel+1) clocks while running.
// A stop request always finishes the current period, so every run ends on a final tick.
// Optional tick counter is built only when TICK_COUNTER_EN is defined; otherwise
// tick_count is tied to zero.
module clk_tick_scheduler #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                 Clck_in,
    input  logic                 reset_Clock,
    clk_tick_scheduler_if.slave  bus_io
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArm   = 2'd1,
        StRun   = 2'd2,
        StDrain = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] presc_q, presc_d;
    logic [1:0] div_q, div_d;
    logic [4:0] period;
    logic [3:0] presc_max;
    logic       counting;
    logic       tick;

    // Terminal prescaler value from the divider latched at start.
    assign period    = 5'd2 << div_q;
    assign presc_max = 4'(period - 5'd1);
    assign counting  = (state_q == StRun) || (state_q == StDrain);
    assign tick      = counting && (presc_q == presc_max);

    // State, prescaler and latched divider registers.
    always_ff @(posedge Clck_in or negedge reset_Clock) begin
        if (!reset_Clock) begin
            state_q <= StIdle;
            presc_q <= 4'd0;
            div_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            div_q   <= div_d;
        end
    end

    // Next-state logic; div_sel is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        div_d   = div_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.run_req) begin
                    div_d   = bus_io.div_sel;
                    presc_d = 4'd0;
                    state_d = StArm;
                end
            end
            StArm: begin
                presc_d = 4'd0;
                state_d = StRun;
            end
            StRun: begin
                presc_d = tick ? 4'd0 : presc_q + 4'd1;
                if (!bus_io.run_req) begin
                    state_d = tick ? StIdle : StDrain;
                end
            end
            StDrain: begin
                presc_d = tick ? 4'd0 : presc_q + 4'd1;
                if (tick) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus_io.run_ack  = (state_q == StRun);
    assign bus_io.busy     = (state_q != StIdle);
    assign bus_io.tick_out = tick;
    assign bus_io.state_o  = state_q;

`ifdef TICK_COUNTER_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Tick counter: cleared on start, counts ticks, holds through IDLE.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle && bus_io.run_req) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge Clck_in or negedge reset_Clock) begin
        if (!reset_Clock) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus_io.tick_count = cnt_q;
`else
    assign bus_io.tick_count = '0;
`endif

endmodule

// File: tb/tb_clk_tick_scheduler.sv
// Randomized + directed bench for clk_tick_scheduler against a timeline model:
// a run is described by its start edge, period and stop flag, and ticks fall at
// multiples of the period after the start.
module tb_clk_tick_scheduler;
    localparam int unsigned CntW = 4;
    localparam int CntMask = (1 << CntW) - 1;

    logic clk;
    logic rst_n;

    clk_tick_scheduler_if #(.CNT_W(CntW)) bus_if ();

    clk_tick_scheduler #(.CNT_W(CntW)) dut (
        .Clck_in     (clk),
        .reset_Clock (rst_n),
        .bus_io      (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Model: active run, edges elapsed since the start edge, period, stop seen, ticks.
    bit m_active;
    int m_el;
    int m_n;
    bit m_stop;
    int m_cnt;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    function automatic bit m_tick();
        return m_active && m_el >= m_n && (m_el % m_n) == 0;
    endfunction

    function automatic int m_state();
        if (!m_active) return 0;
        if (m_el == 0) return 1;
        if (m_stop) return 3;
        return 2;
    endfunction

    task automatic m_reset();
        m_active = 0;
        m_el     = 0;
        m_n      = 2;
        m_stop   = 0;
        m_cnt    = 0;
    endtask

    task automatic m_edge(input bit rr, input int ds);
        bit t;
        if (!m_active) begin
            if (rr) begin
                m_active = 1;
                m_el     = 0;
                m_n      = 2 << ds;
                m_stop   = 0;
                m_cnt    = 0;
            end
        end else begin
            t = m_tick();
            if (t) m_cnt++;
            if (m_el >= 1) begin
                if (!m_stop && !rr) begin
                    if (t) m_active = 0;
                    else m_stop = 1;
                end else if (m_stop && t) begin
                    m_active = 0;
                end
            end
            if (m_active) m_el++;
        end
    endtask

    function automatic int exp_count();
`ifdef TICK_COUNTER_EN
        return m_cnt & CntMask;
`else
        return 0;
`endif
    endfunction

    task automatic compare();
        int s;
        s = m_state();
        check("state_o", int'(bus_if.state_o), s);
        check("run_ack", int'(bus_if.run_ack), int'(s == 2));
        check("busy", int'(bus_if.busy), int'(s != 0));
        check("tick_out", int'(bus_if.tick_out), int'(m_tick()));
        check("tick_count", int'(bus_if.tick_count), exp_count());
    endtask

    // Called at a falling edge: drive, clock once, advance model, compare.
    task automatic step(input bit rr, input int ds);
        bus_if.run_req = rr;
        bus_if.div_sel = 2'(ds);
        @(posedge clk);
        m_edge(rr, ds);
        @(negedge clk);
        compare();
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before the next edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check("rst_state", int'(bus_if.state_o), 0);
        check("rst_tick", int'(bus_if.tick_out), 0);
        check("rst_busy", int'(bus_if.busy), 0);
        check("rst_ack", int'(bus_if.run_ack), 0);
        check("rst_count", int'(bus_if.tick_count), 0);
        @(negedge clk);
        compare();
        rst_n = 1'b1;
    endtask

    task automatic run_until_idle(input bit rr, input int ds);
        int guard = 0;
        while (m_active && guard < 64) begin
            step(rr, ds);
            guard++;
        end
        if (m_active) check("idle_timeout", 1, 0);
    endtask

    initial begin
        int guard;
        m_reset();
        rst_n = 1'b0;
        bus_if.run_req = 1'b1;
        bus_if.div_sel = 2'd2;
        @(negedge clk);
        compare();
        @(negedge clk);
        compare();
        rst_n = 1'b1;

        // div 2: run 10 cycles, then stop cleanly.
        for (int i = 0; i < 10; i++) step(1'b1, 0);
        run_until_idle(1'b0, 0);

        // div 16: drop run_req with prescaler at 5, drain to final tick.
        guard = 0;
        step(1'b1, 3);
        while (m_el != 6 && guard < 40) begin
            step(1'b1, 3);
            guard++;
        end
        run_until_idle(1'b0, 3);
        check("busy_after_drain", int'(bus_if.busy), 0);

        // div 4, then div_sel flips to 3 mid-run; period must stay 4.
        step(1'b1, 1);
        for (int i = 0; i < 14; i++) step(1'b1, 3);
        run_until_idle(1'b0, 3);

        // run_req 1-0-1 inside DRAIN, still high on return to IDLE -> restart.
        step(1'b1, 3);
        for (int i = 0; i < 4; i++) step(1'b1, 3);
        step(1'b0, 1);
        step(1'b1, 1);
        step(1'b0, 1);
        guard = 0;
        while (m_active && guard < 40) begin
            step(1'b1, 1);
            guard++;
        end
        step(1'b1, 1);
        check("restart_arm", int'(bus_if.state_o), 1);
        run_until_idle(1'b0, 1);

        // Reset mid-DRAIN.
        step(1'b1, 3);
        for (int i = 0; i < 4; i++) step(1'b1, 3);
        step(1'b0, 3);
        step(1'b0, 3);
        async_reset();
        step(1'b0, 0);

        // 40 ticks at div 2; counter wraps and ends at 40 mod 16.
        guard = 0;
        step(1'b1, 0);
        while (!(m_cnt == 39 && m_tick()) && guard < 200) begin
            step(1'b1, 0);
            guard++;
        end
        step(1'b0, 0);
`ifdef TICK_COUNTER_EN
        check("count_40", int'(bus_if.tick_count), 8);
`else
        check("count_off", int'(bus_if.tick_count), 0);
`endif
        step(1'b0, 2);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) async_reset();
            else step(1'($urandom_range(0, 99) < 70), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
